// File: rtl/mont_conv_in.sv
// Entry-side Montgomery conversion: result = a * 2^(3W) mod q, computed by
// 3W successive modular doublings behind valid/ready handshakes.
module mont_conv_in #(
  parameter int K = 54,
  parameter int W = 24,
  parameter int M = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] a,
  input  logic [M-1:0] q_m,
  input  logic [3:0]   current_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] result
);

  localparam int TW    = K - M - W;
  localparam int STEPS = 3 * W;
  localparam int CW    = $clog2(STEPS);
  localparam int K_TOP = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [K-1:0]   x;
  logic [CW-1:0]  cnt;
  logic [M-1:0]   q_m_lat;
  logic [3:0]     k_lat;

  logic [K-1:0]   q;
  logic [K:0]     d;
  logic [K:0]     diff;
  logic           borrow;
  logic [K-1:0]   x_step;
  logic           accept;
  logic           last_step;

  // Top field of the modulus: all-ones shortened by (8 - k) bits.
  // Selectors above the legal range saturate at the full-width field.
  function automatic logic [TW-1:0] top_field(input logic [3:0] k);
    logic [TW-1:0] ones;
    logic [3:0]    sh;
    ones = '1;
    sh   = (k >= 4'(K_TOP)) ? 4'd0 : 4'(K_TOP) - k;
    return ones >> sh;
  endfunction

  // q is rebuilt from the latched fields, so it cannot follow the inputs
  // once an operand has been accepted.
  assign q = {top_field(k_lat), q_m_lat, {(W-1){1'b0}}, 1'b1};

  // One modular doubling. q has a zero MSB at K+1 bits, so the borrow of
  // the (K+1)-bit subtraction d - q reduces to ~d[K] & diff[K].
  assign d      = {x, 1'b0};
  assign diff   = d - {1'b0, q};
  assign borrow = ~d[K] & diff[K];
  assign x_step = borrow ? d[K-1:0] : diff[K-1:0];

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(STEPS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; both flags come straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign result = x;

  // Datapath: operand capture at accept, one doubling per RUN cycle,
  // x held untouched in DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      cnt     <= '0;
      q_m_lat <= '0;
      k_lat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x       <= a;
            cnt     <= '0;
            q_m_lat <= q_m;
            k_lat   <= current_k;
          end
        end
        RUN: begin
          x   <= x_step;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
